// File: rtl/adder_pkg.sv
// adder_pkg: shared types and sizing helpers for the serial arithmetic blocks
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;
  function automatic int cnt_w(input int bits);
    return $clog2(bits + 1);
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - b_in through one full adder, valid/ready on both sides
module serial_subtractor
  import adder_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            b_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] diff,
  output logic            borrow,
  output logic            ovf
);
  localparam int CNT_W = cnt_w(BITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BITS - 1);
  sub_state_t state;
  logic [BITS-1:0] a_sh, b_sh, nxt;
  logic [CNT_W-1:0] cnt;
  logic carry, a_msb, b_msb, sum, c_out;
  full_adder u_fa (.a(a_sh[0]), .b(~b_sh[0]), .c_in(carry), .sum(sum), .c_out(c_out));
  // the minuend register doubles as the result accumulator: sums enter at the MSB
  assign nxt       = BITS'({sum, a_sh} >> 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= ~b_in;
          a_msb <= a[BITS-1];
          b_msb <= b[BITS-1];
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          a_sh  <= nxt;
          b_sh  <= b_sh >> 1;
          carry <= c_out;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            diff   <= nxt;
            borrow <= ~c_out;
            ovf    <= (a_msb != b_msb) && (sum != a_msb);
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed BITS=4 scenarios plus random BITS=1/8 sweeps against an arithmetic model
module tb_serial_subtractor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  logic rst = 1'b1;
  logic rst4, iv4, ir4, ov4, or4, bi4, bo4, of4;
  logic [3:0] a4, b4, d4;
  serial_subtractor #(.BITS(4)) u4 (
    .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .b_in(bi4),
    .out_valid(ov4), .out_ready(or4), .diff(d4), .borrow(bo4), .ovf(of4)
  );
  for (genvar g = 0; g < 2; g++) begin : sw
    localparam int W = (g == 0) ? 1 : 8;
    logic iv, ir, ov, orr, bi, bo, of, done;
    logic [W-1:0] a, b, d;
    serial_subtractor #(.BITS(W)) u (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .b_in(bi),
      .out_valid(ov), .out_ready(orr), .diff(d), .borrow(bo), .ovf(of)
    );
    initial begin
      int ops, e, acc, df, ai, bv;
      bit busy;
      logic [W-1:0] ed;
      logic eb, eo;
      ops = 0; e = 0; acc = 0; busy = 0; done = 0;
      iv = 0; orr = 0; a = '0; b = '0; bi = 0; ed = '0; eb = 0; eo = 0;
      do @(negedge clk); while (rst);
      while (ops < 1000 && e < 40000) begin
        @(negedge clk);
        e++;
        check($sformatf("w%0d in_ready", W), ir, !busy);
        check($sformatf("w%0d out_valid", W), ov, busy && (e - acc >= W));
        if (ov && busy) begin
          check($sformatf("w%0d diff", W), d, ed);
          check($sformatf("w%0d borrow", W), bo, eb);
          check($sformatf("w%0d ovf", W), of, eo);
        end
        iv  = 1'($urandom_range(0, 1));
        a   = W'($urandom);
        b   = W'($urandom);
        bi  = 1'($urandom_range(0, 1));
        orr = $urandom_range(0, 2) != 0;
        if (ov && orr) begin
          busy = 0;
          ops++;
        end
        if (iv && ir) begin
          busy = 1;
          acc  = e + 1;
          ai   = int'(a);
          bv   = int'(b);
          df   = ai - bv - int'(bi);
          ed   = df[W-1:0];
          eb   = ai < bv + int'(bi);
          eo   = (a[W-1] != b[W-1]) && (ed[W-1] != a[W-1]);
        end
      end
      check($sformatf("w%0d ops completed", W), 32'(ops >= 1000), 1);
      done = 1;
    end
  end
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                     input logic [3:0] ed, input logic eb, input logic eo);
    int k;
    @(negedge clk);
    a4 = ta; b4 = tb; bi4 = tc; iv4 = 1; or4 = 1; k = 0;
    while (!ir4 && k < 20) begin @(negedge clk); k++; end
    check("op in_ready", ir4, 1);
    @(negedge clk);
    iv4 = 0; k = 0;
    while (!ov4 && k < 20) begin @(negedge clk); k++; end
    check("op latency", k, 4);
    check("op diff", d4, ed);
    check("op borrow", bo4, eb);
    check("op ovf", of4, eo);
    @(negedge clk);
    check("op back to idle", ir4, 1);
    check("op out_valid drop", ov4, 0);
  endtask
  initial begin
    int k;
    bit seen;
    rst4 = 1; iv4 = 0; or4 = 0; a4 = '0; b4 = '0; bi4 = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst in_ready", ir4, 1);
    check("rst out_valid", ov4, 0);
    check("rst diff", d4, 0);
    check("rst borrow", bo4, 0);
    check("rst ovf", of4, 0);
    rst4 = 0;
    op4(4'h7, 4'h3, 0, 4'h4, 0, 0);
    op4(4'h3, 4'h7, 0, 4'hC, 1, 0);
    op4(4'h0, 4'h0, 1, 4'hF, 1, 0);
    op4(4'h8, 4'h1, 0, 4'h7, 0, 1);
    op4(4'h7, 4'hF, 0, 4'h8, 1, 1);
    // backpressure: result held while the next producer keeps pushing
    @(negedge clk);
    a4 = 4'h7; b4 = 4'h3; bi4 = 0; iv4 = 1; or4 = 0;
    @(negedge clk);
    k = 0;
    while (!ov4 && k < 20) begin @(negedge clk); k++; end
    check("bp latency", k, 4);
    repeat (5) begin
      a4 = 4'($urandom); b4 = 4'($urandom);
      @(negedge clk);
      check("bp diff", d4, 4'h4);
      check("bp borrow", bo4, 0);
      check("bp ovf", of4, 0);
      check("bp in_ready", ir4, 0);
      check("bp out_valid", ov4, 1);
    end
    a4 = 4'h5; b4 = 4'h2; bi4 = 0; or4 = 1;
    @(negedge clk);
    check("bp release in_ready", ir4, 1);
    check("bp release out_valid", ov4, 0);
    @(negedge clk);
    check("bp next accepted", ir4, 0);
    iv4 = 0; k = 0;
    while (!ov4 && k < 20) begin @(negedge clk); k++; end
    check("bp2 latency", k, 4);
    check("bp2 diff", d4, 4'h3);
    check("bp2 borrow", bo4, 0);
    @(negedge clk);
    // reset after two bits of an operation
    a4 = 4'h9; b4 = 4'h2; bi4 = 0; iv4 = 1; or4 = 1;
    @(negedge clk);
    iv4 = 0;
    repeat (2) @(negedge clk);
    rst4 = 1;
    @(negedge clk);
    rst4 = 0;
    check("mid rst in_ready", ir4, 1);
    check("mid rst out_valid", ov4, 0);
    check("mid rst diff", d4, 0);
    check("mid rst borrow", bo4, 0);
    check("mid rst ovf", of4, 0);
    seen = 0;
    repeat (6) begin @(negedge clk); seen |= ov4; end
    check("aborted op silent", seen, 0);
    op4(4'hA, 4'h3, 1, 4'h6, 0, 1);
    k = 0;
    while (!(sw[0].done && sw[1].done) && k < 90000) begin @(negedge clk); k++; end
    check("sweeps finished", 32'(sw[0].done && sw[1].done), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
